avalon_burst_arbiter: RTL and testbench

Two-requester arbiter that shares one Avalon-MM burst master port to external memory between the data cache (requester 0) and the instruction cache (requester 1). Grants one requester at a time and holds the grant for the whole burst: all write beats accepted, or all read beats returned. Placed between the cache line-fill/write-back masters and the SDRAM controller port.

---
 rtl/avalon_arb_pkg.sv | 15 +
 rtl/avalon_arb_pick.sv | 38 +++
 rtl/avalon_burst_arbiter.sv | 147 ++++++++++++++
 tb/tb_avalon_burst_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// rtl/avalon_arb_pkg.sv - shared types and constants for the Avalon burst arbiter
// Contents: arb_state_e (IDLE, WR, RD_CMD, RD_DATA), requester indices REQ_DCACHE / REQ_ICACHE.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_DATA = 2'd3
  } arb_state_e;

  localparam logic REQ_DCACHE = 1'b0;
  localparam logic REQ_ICACHE = 1'b1;

endpackage

// File: rtl/avalon_arb_pick.sv
// rtl/avalon_arb_pick.sv - combinational two-way winner select
// Ports: pending0_i/pending1_i request pending, last_grant_i previous winner,
//        grant_valid_o any request pending, grant_idx_o winning requester.
// Build option: AVALON_ARB_ROUND_ROBIN_EN selects round-robin tie break;
//               otherwise requester 0 wins every tie.
module avalon_arb_pick (
  input  logic pending0_i,
  input  logic pending1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);
  import avalon_arb_pkg::*;

  always_comb begin
    grant_valid_o = pending0_i | pending1_i;
    grant_idx_o   = REQ_DCACHE;
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    // Tie goes to whoever did not win last time.
    if (pending0_i && pending1_i) begin
      grant_idx_o = ~last_grant_i;
    end else if (pending1_i) begin
      grant_idx_o = REQ_ICACHE;
    end
`else
    if (pending1_i && !pending0_i) begin
      grant_idx_o = REQ_ICACHE;
    end
`endif
  end

`ifndef AVALON_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/avalon_burst_arbiter.sv
// rtl/avalon_burst_arbiter.sv - two-requester Avalon-MM burst arbiter (D-cache = 0, I-cache = 1)
// Ports: rqN_* Avalon-MM burst slave ports of requester N (address, burstcount, read,
//        write, writedata in; waitrequest, readdata, readdatavalid out);
//        mem_* Avalon-MM burst master port toward the memory controller.
// Grant is held for a whole burst (all write beats accepted / all read beats returned).
// Build option: AVALON_ARB_ROUND_ROBIN_EN (round-robin ties, handled in avalon_arb_pick).
module avalon_burst_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_WIDTH = 7,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  rq0_address,
  input  logic [BURST_WIDTH-1:0] rq0_burstcount,
  input  logic                   rq0_read,
  input  logic                   rq0_write,
  input  logic [DATA_WIDTH-1:0]  rq0_writedata,
  output logic                   rq0_waitrequest,
  output logic [DATA_WIDTH-1:0]  rq0_readdata,
  output logic                   rq0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]  rq1_address,
  input  logic [BURST_WIDTH-1:0] rq1_burstcount,
  input  logic                   rq1_read,
  input  logic                   rq1_write,
  input  logic [DATA_WIDTH-1:0]  rq1_writedata,
  output logic                   rq1_waitrequest,
  output logic [DATA_WIDTH-1:0]  rq1_readdata,
  output logic                   rq1_readdatavalid,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [BURST_WIDTH-1:0] mem_burstcount,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [DATA_WIDTH-1:0]  mem_writedata,
  input  logic                   mem_waitrequest,
  input  logic                   mem_readdatavalid,
  input  logic [DATA_WIDTH-1:0]  mem_readdata
);

  localparam logic [BURST_WIDTH-1:0] BEAT_ONE = BURST_WIDTH'(1);

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [BURST_WIDTH-1:0] beats_left_q, beats_left_d;

  logic grant_valid;
  logic grant_idx;

  avalon_arb_pick u_pick (
    .pending0_i    (rq0_read | rq0_write),
    .pending1_i    (rq1_read | rq1_write),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Owner's request signals, muxed once and shared by next-state and output logic.
  logic                   own_read, own_write;
  logic [ADDR_WIDTH-1:0]  own_address;
  logic [BURST_WIDTH-1:0] own_burstcount;
  logic [DATA_WIDTH-1:0]  own_writedata;

  assign own_read       = owner_q ? rq1_read       : rq0_read;
  assign own_write      = owner_q ? rq1_write      : rq0_write;
  assign own_address    = owner_q ? rq1_address    : rq0_address;
  assign own_burstcount = owner_q ? rq1_burstcount : rq0_burstcount;
  assign own_writedata  = owner_q ? rq1_writedata  : rq0_writedata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          beats_left_d = grant_idx ? rq1_burstcount : rq0_burstcount;
          // A requester asserting read and write together is treated as a write.
          state_d      = (grant_idx ? rq1_write : rq0_write) ? WR : RD_CMD;
        end
      end
      WR: begin
        if (own_write && !mem_waitrequest) begin
          beats_left_d = beats_left_q - BEAT_ONE;
          if (beats_left_q == BEAT_ONE) begin
            state_d = IDLE;
          end
        end
      end
      RD_CMD: begin
        if (own_read && !mem_waitrequest) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_readdatavalid) begin
          beats_left_d = beats_left_q - BEAT_ONE;
          if (beats_left_q == BEAT_ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= REQ_DCACHE;
      last_grant_q <= REQ_ICACHE;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Outputs decode straight from state_q so an asynchronous reset takes effect at once.
  logic own_wait;
  logic rd_beat;

  always_comb begin
    mem_address    = own_address;
    mem_burstcount = own_burstcount;
    mem_writedata  = own_writedata;
    // Strobes are qualified by state so a stray strobe of the wrong kind never leaks out.
    mem_write      = (state_q == WR) && own_write;
    mem_read       = (state_q == RD_CMD) && own_read;
    own_wait       = ((state_q == WR) || (state_q == RD_CMD)) ? mem_waitrequest : 1'b1;
    rq0_waitrequest = (owner_q == REQ_DCACHE) ? own_wait : 1'b1;
    rq1_waitrequest = (owner_q == REQ_ICACHE) ? own_wait : 1'b1;
    rd_beat         = (state_q == RD_DATA) && mem_readdatavalid;
    rq0_readdatavalid = rd_beat && (owner_q == REQ_DCACHE);
    rq1_readdatavalid = rd_beat && (owner_q == REQ_ICACHE);
    rq0_readdata      = mem_readdata;
    rq1_readdata      = mem_readdata;
  end

endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// tb/tb_avalon_burst_arbiter.sv - scoreboard bench for avalon_burst_arbiter
module tb_avalon_burst_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] rq0_address, rq1_address;
  logic [6:0]  rq0_burstcount, rq1_burstcount;
  logic        rq0_read, rq1_read, rq0_write, rq1_write;
  logic [31:0] rq0_writedata, rq1_writedata;
  logic        rq0_waitrequest, rq1_waitrequest;
  logic [31:0] rq0_readdata, rq1_readdata;
  logic        rq0_readdatavalid, rq1_readdatavalid;
  logic [31:0] mem_address;
  logic [6:0]  mem_burstcount;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest, mem_readdatavalid;
  logic [31:0] mem_readdata;

  avalon_burst_arbiter #(.ADDR_WIDTH(32), .BURST_WIDTH(7), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_address(rq0_address), .rq0_burstcount(rq0_burstcount), .rq0_read(rq0_read),
    .rq0_write(rq0_write), .rq0_writedata(rq0_writedata), .rq0_waitrequest(rq0_waitrequest),
    .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_burstcount(rq1_burstcount), .rq1_read(rq1_read),
    .rq1_write(rq1_write), .rq1_writedata(rq1_writedata), .rq1_waitrequest(rq1_waitrequest),
    .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
    .mem_address(mem_address), .mem_burstcount(mem_burstcount), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic is_wr; logic [31:0] addr; logic [6:0] bc; logic [31:0] data; } mem_ev_t;
  typedef struct { logic idx; logic [31:0] data; } rd_ev_t;

  mem_ev_t exp_mem[$];
  rd_ev_t  exp_rd[$];
  int checks = 0;
  int errors = 0;
  int rd_cnt0 = 0;
  int rd_cnt1 = 0;
  int flush_req = 0;
  int abort_req = 0;
  int stray_req = 0;
  int mem_mode = 0;   // 0: ready, 1: toggle waitrequest, 2: hold waitrequest high

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wdata(input logic idx, input int i);
    return 32'hD000_0000 + (idx ? 32'h0001_0000 : 32'h0) + 32'(i);
  endfunction

  task automatic push_wr(input logic idx, input logic [31:0] a, input int bc);
    for (int i = 0; i < bc; i++) exp_mem.push_back('{1'b1, a, 7'(bc), wdata(idx, i)});
  endtask

  task automatic push_rd(input logic idx, input logic [31:0] a, input int bc);
    exp_mem.push_back('{1'b0, a, 7'(bc), 32'h0});
    for (int i = 0; i < bc; i++) exp_rd.push_back('{idx, a + 32'(i)});
  endtask

  task automatic drive(input logic idx, input logic rd, input logic wr, input logic [31:0] a,
                       input int bc, input logic [31:0] d);
    if (!idx) begin
      rq0_read = rd; rq0_write = wr; rq0_address = a; rq0_burstcount = 7'(bc); rq0_writedata = d;
    end else begin
      rq1_read = rd; rq1_write = wr; rq1_address = a; rq1_burstcount = 7'(bc); rq1_writedata = d;
    end
  endtask

  // Holds read until the command is taken; stalls = cycles spent with waitrequest high.
  task automatic issue_read(input logic idx, input logic [31:0] a, input int bc, output int stalls);
    logic w;
    bit done = 0;
    stalls = 0;
    drive(idx, 1'b1, 1'b0, a, bc, 32'h0);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      w = idx ? rq1_waitrequest : rq0_waitrequest;
      @(posedge clk); #1;
      if (!w) done = 1; else stalls++;
    end
    drive(idx, 1'b0, 1'b0, a, bc, 32'h0);
    if (!done) chk("read command timeout", 64'(stalls), 64'(-1));
  endtask

  // Write burst with optional pause of pause_len cycles after beat pause_after.
  task automatic issue_write(input logic idx, input logic [31:0] a, input int bc,
                             input int pause_after, input int pause_len,
                             output int first_lat, output int cyc, output logic other_ok);
    logic w, ow;
    logic wr_on = 1'b1;
    int beat = 0;
    int pause_left = 0;
    first_lat = -1; cyc = 0; other_ok = 1'b1;
    drive(idx, 1'b0, 1'b1, a, bc, wdata(idx, 0));
    while (beat < bc && cyc < 400) begin
      @(negedge clk);
      w  = idx ? rq1_waitrequest : rq0_waitrequest;
      ow = idx ? rq0_waitrequest : rq1_waitrequest;
      if (!ow) other_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (wr_on && !w) begin
        if (first_lat < 0) first_lat = cyc - 1;
        beat++;
        if (beat == pause_after) begin wr_on = 1'b0; pause_left = pause_len; end
      end else if (!wr_on) begin
        pause_left--;
        if (pause_left <= 0) wr_on = 1'b1;
      end
      drive(idx, 1'b0, wr_on && (beat < bc), a, bc, wdata(idx, beat));
    end
    if (beat < bc) chk("write burst timeout", 64'(beat), 64'(bc));
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while ((exp_rd.size() != 0 || exp_mem.size() != 0) && c < 400) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 64'(exp_rd.size() + exp_mem.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory model: accepts a read command, returns one beat per cycle of address + beat index.
  initial begin
    logic acc;
    logic [31:0] acc_addr, rd_addr;
    logic [6:0] acc_bc;
    int rd_left = 0, rd_idx = 0, abort_seen = 0, stray_seen = 0;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = 32'h0;
    forever begin
      @(negedge clk);
      acc = mem_read && !mem_waitrequest && rst_n;
      acc_addr = mem_address; acc_bc = mem_burstcount;
      @(posedge clk); #2;
      if (abort_seen != abort_req) begin abort_seen = abort_req; rd_left = 0; acc = 1'b0; end
      if (rd_left > 0) begin
        mem_readdatavalid = 1'b1; mem_readdata = rd_addr + 32'(rd_idx); rd_idx++; rd_left--;
      end else if (stray_seen != stray_req) begin
        stray_seen = stray_req; mem_readdatavalid = 1'b1; mem_readdata = 32'hBAD0_0001;
      end else begin
        mem_readdatavalid = 1'b0;
      end
      if (acc) begin rd_left = int'(acc_bc); rd_addr = acc_addr; rd_idx = 0; end
      if (mem_mode == 0) mem_waitrequest = 1'b0;
      else if (mem_mode == 2) mem_waitrequest = 1'b1;
      else mem_waitrequest = ~mem_waitrequest;
    end
  end

  // Monitor: pops the scoreboard on every accepted mem beat/command and every read beat.
  initial begin
    mem_ev_t e;
    rd_ev_t r;
    int flush_done = 0;
    forever begin
      @(negedge clk);
      if (flush_done != flush_req) begin flush_done = flush_req; exp_rd.delete(); end
      if (rst_n && mem_write && !mem_waitrequest) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++; $display("FAIL unexpected write beat: data %0h", mem_writedata);
        end else begin
          e = exp_mem.pop_front();
          chk("beat kind (1=write)", 64'(e.is_wr), 64'd1);
          chk("write address", 64'(mem_address), 64'(e.addr));
          chk("write burstcount", 64'(mem_burstcount), 64'(e.bc));
          chk("write data", 64'(mem_writedata), 64'(e.data));
        end
      end
      if (rst_n && mem_read && !mem_waitrequest) begin
        if (exp_mem.size() == 0) begin
          checks++; errors++; $display("FAIL unexpected read command: addr %0h", mem_address);
        end else begin
          e = exp_mem.pop_front();
          chk("command kind (0=read)", 64'(e.is_wr), 64'd0);
          chk("read address", 64'(mem_address), 64'(e.addr));
          chk("read burstcount", 64'(mem_burstcount), 64'(e.bc));
        end
      end
      if (rq0_readdatavalid || rq1_readdatavalid) begin
        if (rq1_readdatavalid) rd_cnt1++; else rd_cnt0++;
        chk("single readdatavalid", 64'(rq0_readdatavalid && rq1_readdatavalid), 64'd0);
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected readdatavalid: rq0 %0b rq1 %0b data %0h",
                   rq0_readdatavalid, rq1_readdatavalid, rq0_readdata);
        end else begin
          r = exp_rd.pop_front();
          chk("read beat requester", 64'(rq1_readdatavalid), 64'(r.idx));
          chk("rq0 readdata", 64'(rq0_readdata), 64'(r.data));
          chk("rq1 readdata", 64'(rq1_readdata), 64'(r.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cyc, s0, s1, base;
    logic ok;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    #1;
    chk("reset rq0_waitrequest", 64'(rq0_waitrequest), 64'd1);
    chk("reset rq1_waitrequest", 64'(rq1_waitrequest), 64'd1);
    chk("reset mem_read", 64'(mem_read), 64'd0);
    chk("reset mem_write", 64'(mem_write), 64'd0);
    chk("reset readdatavalid", 64'({rq0_readdatavalid, rq1_readdatavalid}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // rq0 write burst of 16, memory always ready, then a back-to-back rq1 read.
    push_wr(1'b0, 32'h0000_1000, 16);
    issue_write(1'b0, 32'h0000_1000, 16, 0, 0, lat, cyc, ok);
    chk("write first-beat latency", 64'(lat), 64'd1);
    chk("write burst cycles", 64'(cyc), 64'd17);
    chk("rq1 stalled during rq0 write", 64'(ok), 64'd1);
    push_rd(1'b1, 32'h0000_2000, 2);
    issue_read(1'b1, 32'h0000_2000, 2, s1);
    chk("idle cycle before next grant", 64'(s1), 64'd1);
    wait_drain("drain after write burst");

    // rq1 read of 16 with memory stalling the command for 3 cycles.
    mem_mode = 2;
    @(posedge clk); #1;
    push_rd(1'b1, 32'h0000_3000, 16);
    fork
      issue_read(1'b1, 32'h0000_3000, 16, s1);
      begin repeat (4) @(posedge clk); #1 mem_mode = 0; end
    join
    chk("stalled read accept cycle", 64'(s1), 64'd4);
    wait_drain("drain after stalled read");

    // Two ties in a row: rq0 re-requests right as its first burst completes.
    push_rd(1'b0, 32'h0000_4000, 4);
`ifdef AVALON_ARB_ROUND_ROBIN_EN
    push_rd(1'b1, 32'h0000_5000, 4);
    push_rd(1'b0, 32'h0000_6000, 4);
`else
    push_rd(1'b0, 32'h0000_6000, 4);
    push_rd(1'b1, 32'h0000_5000, 4);
`endif
    base = rd_cnt0;
    fork
      begin
        issue_read(1'b0, 32'h0000_4000, 4, s0);
        for (int c = 0; c < 200 && rd_cnt0 < base + 4; c++) begin @(posedge clk); #1; end
        issue_read(1'b0, 32'h0000_6000, 4, s0);
      end
      issue_read(1'b1, 32'h0000_5000, 4, s1);
    join
    wait_drain("drain after tie reads");

    // Write with toggling waitrequest and a 2-cycle pause; rq1 requests mid-burst.
    mem_mode = 1;
    push_wr(1'b0, 32'h0000_7000, 16);
    push_rd(1'b1, 32'h0000_8000, 4);
    fork
      issue_write(1'b0, 32'h0000_7000, 16, 5, 2, lat, cyc, ok);
      begin repeat (3) @(posedge clk); #1; issue_read(1'b1, 32'h0000_8000, 4, s1); end
    join
    chk("grant held through paused write", 64'(ok), 64'd1);
    chk("paused write burst cycles (>= 19)", 64'(cyc >= 19), 64'd1);
    mem_mode = 0;
    wait_drain("drain after toggled write");

    // Stray readdatavalid while idle.
    stray_req++;
    @(negedge clk);
    chk("stray valid: rq readdatavalid", 64'({rq0_readdatavalid, rq1_readdatavalid}), 64'd0);
    chk("stray valid: waitrequests", 64'({rq0_waitrequest, rq1_waitrequest}), 64'd3);
    @(posedge clk); #1;
    push_rd(1'b0, 32'h0000_9000, 2);
    issue_read(1'b0, 32'h0000_9000, 2, s0);
    chk("read grant after stray valid", 64'(s0), 64'd1);
    wait_drain("drain after stray valid");

    // Reset after beat 5 of a 16-beat read, then a clean rq1 read.
    base = rd_cnt0;
    push_rd(1'b0, 32'h0000_A000, 16);
    issue_read(1'b0, 32'h0000_A000, 16, s0);
    for (int c = 0; c < 100 && rd_cnt0 < base + 5; c++) begin @(negedge clk); #2; end
    chk("beats before reset", 64'(rd_cnt0 - base), 64'd5);
    rst_n = 1'b0;
    abort_req++;
    flush_req++;
    #1;
    chk("mid-burst reset mem_read", 64'(mem_read), 64'd0);
    chk("mid-burst reset mem_write", 64'(mem_write), 64'd0);
    chk("mid-burst reset waitrequests", 64'({rq0_waitrequest, rq1_waitrequest}), 64'd3);
    chk("mid-burst reset readdatavalid", 64'({rq0_readdatavalid, rq1_readdatavalid}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push_rd(1'b1, 32'h0000_B000, 4);
    issue_read(1'b1, 32'h0000_B000, 4, s1);
    chk("rq1 grant after reset", 64'(s1), 64'd1);
    wait_drain("drain after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
